// File: rtl/alu_4bit_issue.sv
// alu_4bit_issue
// Command issue / accumulator stage feeding a 4-bit combinational ALU.
// Commands {load, op, b} are queued in a DEPTH-entry FIFO, executed one at a
// time against the internal accumulator, and each result is returned on a
// valid/ready response channel.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_op, cmd_b, cmd_load payload
//   alu_a/alu_b/alu_op       operands to the external ALU (alu_a is always acc)
//   alu_result/carry/zero    ALU outputs, captured at the end of EXEC
//   res_valid/res_ready      response handshake; res_data/res_carry/res_zero
//   acc                      current accumulator
//   fifo_count               occupied command FIFO entries
//   busy                     FSM not idle or FIFO non-empty
module alu_4bit_issue #(
    parameter int DEPTH = 4,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [3:0]    cmd_b,
    input  logic          cmd_load,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [2:0]    alu_op,
    input  logic [3:0]    alu_result,
    input  logic          alu_carry,
    input  logic          alu_zero,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [3:0]    res_data,
    output logic          res_carry,
    output logic          res_zero,
    output logic [3:0]    acc,
    output logic [CW:0]   fifo_count,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam int          EW   = 8;             // {load, op[2:0], b[3:0]}
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW:0]   count_q, count_d;
    logic [EW-1:0] exec_q, exec_d;                // command currently executing
    logic [3:0]    acc_q, acc_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;
    logic [3:0]    res_data_q, res_data_d;
    logic          res_carry_q, res_carry_d;
    logic          res_zero_q, res_zero_d;

    logic          push;
    logic          pop;
    logic          exec_load;
    logic [3:0]    exec_b;

    assign exec_load = exec_q[7];
    assign exec_b    = exec_q[3:0];

    assign cmd_ready = (count_q != FULL);
    assign push      = cmd_valid & cmd_ready;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            exec_q      <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            exec_q      <= exec_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
        end
    end

    // FIFO storage: no reset needed, pointers define validity
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= {cmd_load, cmd_op, cmd_b};
        end
    end

    // Next-state logic; pop is decided here since it is tied to transitions
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + (CW + 1)'(push) - (CW + 1)'(pop);
        exec_d      = exec_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + CW'(1);
        end
        // Registered read of the head entry straight into the exec register
        if (pop) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
            exec_d   = mem[rd_ptr_q];
        end

        if (state_q == EXEC) begin
            if (exec_load) begin
                acc_d   = exec_b;
                carry_d = 1'b0;
                zero_d  = (exec_b == 4'd0);
            end else begin
                acc_d   = alu_result;
                carry_d = alu_carry;
                zero_d  = alu_zero;
            end
            res_data_d  = acc_d;
            res_carry_d = carry_d;
            res_zero_d  = zero_d;
        end
    end

    // Outputs
    always_comb begin
        res_valid  = (state_q == RESP);
        busy       = (state_q != IDLE) || (count_q != '0);
        alu_a      = acc_q;
        alu_b      = exec_q[3:0];
        alu_op     = exec_q[6:4];
        res_data   = res_data_q;
        res_carry  = res_carry_q;
        res_zero   = res_zero_q;
        acc        = acc_q;
        fifo_count = count_q;
    end

endmodule

// File: tb/tb_alu_4bit_issue.sv
module tb_alu_4bit_issue;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_b;
    logic       cmd_load;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic [3:0] acc;
    logic [2:0] fifo_count;
    logic       busy;

    alu_4bit_issue #(.DEPTH(4), .CW(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_b(cmd_b), .cmd_load(cmd_load),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
        .acc(acc), .fifo_count(fifo_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer-arithmetic ALU: returns {carry, result}; carry is the borrow for SUB/DEC
    function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ai;
        int bi;
        int r;
        logic c;
        ai = int'(a);
        bi = int'(b);
        c = 1'b0;
        case (op)
            3'd0: r = ai & bi;
            3'd1: r = ai | bi;
            3'd2: begin r = ai + bi; c = (r > 15); end
            3'd3: begin r = ai - bi; c = (r < 0); end
            3'd4: r = ai ^ bi;
            3'd5: r = 15 - ai;
            3'd6: begin r = ai + 1; c = (r > 15); end
            default: begin r = ai - 1; c = (r < 0); end
        endcase
        r = r & 15;
        return {c, r[3:0]};
    endfunction

    // Environment ALU driven by the DUT
    always_comb begin
        {alu_carry, alu_result} = alu_fn(alu_op, alu_a, alu_b);
        alu_zero = (alu_result == 4'd0);
    end

    typedef struct packed {
        logic [3:0] d;
        logic       c;
        logic       z;
    } resp_t;

    resp_t      exp_q[$];
    logic [3:0] m_acc;
    resp_t      last;
    int         total;
    int         bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Commands execute strictly in order, so the expected response is known at acceptance
    task automatic model_push(input logic l, input logic [2:0] op, input logic [3:0] b);
        resp_t e;
        logic [4:0] r;
        if (l) begin
            e.d = b; e.c = 1'b0; e.z = (b == 4'd0);
        end else begin
            r = alu_fn(op, m_acc, b);
            e.d = r[3:0]; e.c = r[4]; e.z = (r[3:0] == 4'd0);
        end
        m_acc = e.d;
        exp_q.push_back(e);
    endtask

    // One clock cycle with handshake tracking and response checking
    task automatic tick();
        logic  was_rst;
        logic  do_push;
        logic  do_pop;
        logic  held;
        resp_t held_v;
        resp_t e;
        was_rst = rst;
        do_push = cmd_valid && cmd_ready && !rst;
        do_pop  = res_valid && res_ready && !rst;
        held    = res_valid && !res_ready && !rst;
        held_v  = {res_data, res_carry, res_zero};
        if (do_pop) begin
            chk("resp_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res_data", 32'(res_data), 32'(e.d));
                chk("res_carry", 32'(res_carry), 32'(e.c));
                chk("res_zero", 32'(res_zero), 32'(e.z));
                last = {res_data, res_carry, res_zero};
            end
        end
        if (do_push) model_push(cmd_load, cmd_op, cmd_b);
        @(posedge clk);
        #1;
        if (was_rst) begin
            exp_q.delete();
            m_acc = 4'd0;
        end else begin
            if (do_pop) chk("no_b2b_valid", 32'(res_valid), 0);
            if (held) chk("res_held", 32'({res_valid, res_data, res_carry, res_zero}), 32'({1'b1, held_v}));
        end
    endtask

    task automatic push(input logic l, input logic [2:0] op, input logic [3:0] b);
        logic ok;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_load = l; cmd_op = op; cmd_b = b;
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        chk("push_accepted", 32'(ok), 1);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) tick();
        chk("drain_done", 32'(exp_q.size() == 0 && !busy), 1);
        chk("acc_model", 32'(acc), 32'(m_acc));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_acc"}, 32'(acc), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_fifo_count"}, 32'(fifo_count), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    logic [3:0] v;
    logic [3:0] first_v;
    logic [3:0] sixth_v;
    logic       ok6;

    initial begin
        total = 0; bad = 0; m_acc = 4'd0; last = '0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_b = 4'd0; cmd_load = 1'b0; res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_reset_state("reset");
        chk("reset_alu_op", 32'(alu_op), 0);
        chk("reset_alu_b", 32'(alu_b), 0);
        chk("reset_res", 32'({res_data, res_carry, res_zero}), 0);

        // LOAD 0101: exact 2-cycle latency
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_op = 3'd0; cmd_b = 4'b0101;
        chk("lat_cmd_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        chk("lat_k_valid", 32'(res_valid), 0);
        chk("lat_k_count", 32'(fifo_count), 1);
        chk("lat_k_busy", 32'(busy), 1);
        tick();
        chk("lat_k1_valid", 32'(res_valid), 0);
        chk("lat_k1_alu_b", 32'(alu_b), 5);
        chk("lat_k1_count", 32'(fifo_count), 0);
        tick();
        chk("lat_k2_valid", 32'(res_valid), 1);
        chk("lat_k2_data", 32'({res_data, res_carry, res_zero}), 32'({4'b0101, 1'b0, 1'b0}));
        chk("lat_k2_acc", 32'(acc), 5);
        drain();

        // LOAD 7, ADD 1
        res_ready = 1'b1;
        push(1'b1, 3'd0, 4'd7);
        push(1'b0, 3'd2, 4'd1);
        drain();
        chk("add_last", 32'(last), 32'({4'd8, 1'b0, 1'b0}));

        // LOAD F, INC -> wrap with carry
        push(1'b1, 3'd0, 4'hF);
        push(1'b0, 3'd6, 4'd0);
        drain();
        chk("inc_last", 32'(last), 32'({4'd0, 1'b1, 1'b1}));
        chk("inc_acc", 32'(acc), 0);

        // Back-pressure: fill FIFO behind a held response
        res_ready = 1'b0;
        first_v = 4'($urandom_range(0, 15));
        push(1'b1, 3'd0, first_v);
        for (int i = 0; i < 4; i++) push(1'b1, 3'd0, 4'($urandom_range(0, 15)));
        sixth_v = 4'($urandom_range(0, 15));
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_op = 3'd0; cmd_b = sixth_v;
        for (int i = 0; i < 4; i++) begin
            chk("full_count", 32'(fifo_count), 4);
            chk("full_cmd_ready", 32'(cmd_ready), 0);
            chk("hold_acc", 32'(acc), 32'(first_v));
            tick();
        end
        res_ready = 1'b1;
        ok6 = 1'b0;
        for (int i = 0; i < 20 && !ok6; i++) begin
            ok6 = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        chk("sixth_accepted", 32'(ok6), 1);
        chk("refill_count", 32'(fifo_count), 4);
        drain();
        chk("sixth_last", 32'(last[5:2]), 32'(sixth_v));

        // Reset during RESP with 3 queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b1, 3'd0, 4'(i + 3));
        chk("pre_rst_resp_valid", 32'(res_valid), 1);
        chk("pre_rst_resp_count", 32'(fifo_count), 3);
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset_state("rst_resp");
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_resp_no_stale", 32'(res_valid), 0);
        end

        // Reset during EXEC with 3 queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b1, 3'd0, 4'(i + 9));
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_b = 4'd2; res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0; res_ready = 1'b0;
        chk("pre_rst_exec_valid", 32'(res_valid), 0);
        chk("pre_rst_exec_alu_b", 32'(alu_b), 10);
        chk("pre_rst_exec_count", 32'(fifo_count), 3);
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset_state("rst_exec");
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_exec_no_stale", 32'(res_valid), 0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 9) < 6);
            cmd_load  = ($urandom_range(0, 4) == 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_b     = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
